// File: rtl/ext_interrupt_controller_if.sv
// EIC request/acknowledge handshake between the
// external interrupt controller and the core.
interface ext_interrupt_controller_if #(
  parameter int ID_W = 3
);
  logic            EIC_IntReq;
  logic [ID_W-1:0] EIC_IntId;
  logic            EIC_IntAck;

  modport master (
    output EIC_IntReq,
    output EIC_IntId,
    input  EIC_IntAck
  );

  modport slave (
    input  EIC_IntReq,
    input  EIC_IntId,
    output EIC_IntAck
  );
endinterface

// File: rtl/ext_interrupt_controller.sv
// External interrupt controller: sync, pending,
// masking, edge/level modes and EIC arbitration.
module ext_interrupt_controller #(
  parameter int NUM_SRC = 8,
  parameter int ID_W = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ARB_RR = 0,
  parameter logic [NUM_SRC-1:0] EDGE_RST = '1
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Int_Src,
  input  logic               Cfg_Wen,
  input  logic               Cfg_Sel,
  input  logic [NUM_SRC-1:0] Cfg_WData,
  output logic [NUM_SRC-1:0] Int_Mask,
  output logic [NUM_SRC-1:0] Int_Mode,
  output logic [NUM_SRC-1:0] Int_Pending,
  ext_interrupt_controller_if.master eic
);

  typedef enum logic [1:0] {
    stIdle,
    stReq,
    stGap
  } stateT;

  localparam int PW = ID_W + 1;

  logic [NUM_SRC-1:0] syncQ [SYNC_STAGES];
  logic [NUM_SRC-1:0] syncS;
  logic [NUM_SRC-1:0] prevQ;
  logic [NUM_SRC-1:0] maskQ;
  logic [NUM_SRC-1:0] modeQ;
  logic [NUM_SRC-1:0] pendQ;
  logic [NUM_SRC-1:0] pendNext;
  logic [NUM_SRC-1:0] riseS;
  logic [NUM_SRC-1:0] ackClr;
  logic [NUM_SRC-1:0] modeClr;
  logic [NUM_SRC-1:0] eligible;

  stateT           state;
  stateT           stateN;
  logic            reqQ;
  logic            reqN;
  logic [ID_W-1:0] idQ;
  logic [ID_W-1:0] idN;
  logic [ID_W-1:0] rrPtr;
  logic [ID_W-1:0] rrN;
  logic [ID_W-1:0] basePtr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] nextPtr;
  logic [PW-1:0]   incW;
  logic [PW-1:0]   scanW;
  logic            anyElig;
  logic            ackHit;

  assign syncS = syncQ[SYNC_STAGES-1];

  // Synchronise raw lines, keep one cycle of history.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        syncQ[i] <= '0;
      prevQ <= '0;
    end else begin
      syncQ[0] <= Int_Src;
      for (int i = 1; i < SYNC_STAGES; i++)
        syncQ[i] <= syncQ[i-1];
      prevQ <= syncS;
    end
  end

  // Mask and trigger-mode configuration registers.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      maskQ <= '1;
      modeQ <= EDGE_RST;
    end else if (Cfg_Wen) begin
      if (Cfg_Sel)
        modeQ <= Cfg_WData;
      else
        maskQ <= Cfg_WData;
    end
  end

  assign ackHit = (state == stReq) && eic.EIC_IntAck;
  assign riseS = syncS & ~prevQ;
  assign ackClr = ackHit
    ? (NUM_SRC'(1) << idQ) : '0;
  assign modeClr = (Cfg_Wen && Cfg_Sel)
    ? (Cfg_WData ^ modeQ) : '0;
  // Edge bits: a new rise beats the ack clear.
  assign pendNext =
    ((modeQ & (riseS | (pendQ & ~ackClr)))
    | (~modeQ & syncS)) & ~modeClr;

  // Pending bits.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset)
      pendQ <= '0;
    else
      pendQ <= pendNext;
  end

  assign eligible = pendQ & ~maskQ;
  assign basePtr = (ARB_RR != 0) ? rrPtr : '0;

  // First eligible source at or after basePtr, wrapping.
  always_comb begin
    winner = '0;
    anyElig = 1'b0;
    scanW = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scanW = {1'b0, basePtr} + PW'(k);
      if (scanW >= PW'(NUM_SRC))
        scanW = scanW - PW'(NUM_SRC);
      if (!anyElig && eligible[scanW[ID_W-1:0]]) begin
        anyElig = 1'b1;
        winner = scanW[ID_W-1:0];
      end
    end
  end

  assign incW = {1'b0, idQ} + PW'(1);
  assign nextPtr = (incW >= PW'(NUM_SRC))
    ? '0 : incW[ID_W-1:0];

  // Handshake next-state and registered outputs.
  always_comb begin
    stateN = state;
    reqN = reqQ;
    idN = idQ;
    rrN = rrPtr;
    unique case (state)
      stIdle: begin
        if (anyElig) begin
          stateN = stReq;
          reqN = 1'b1;
          idN = winner;
        end
      end
      stReq: begin
        if (ackHit) begin
          stateN = stGap;
          reqN = 1'b0;
          if (ARB_RR != 0)
            rrN = nextPtr;
        end
      end
      stGap: stateN = stIdle;
      default: begin
        stateN = stIdle;
        reqN = 1'b0;
      end
    endcase
  end

  // Handshake state register.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      state <= stIdle;
      reqQ <= 1'b0;
      idQ <= '0;
      rrPtr <= '0;
    end else begin
      state <= stateN;
      reqQ <= reqN;
      idQ <= idN;
      rrPtr <= rrN;
    end
  end

  assign eic.EIC_IntReq = reqQ;
  assign eic.EIC_IntId = idQ;
  assign Int_Mask = maskQ;
  assign Int_Mode = modeQ;
  assign Int_Pending = pendQ;

endmodule

// File: tb/tb_ext_interrupt_controller.sv
// Bench: fixed-priority and round-robin controllers
// driven together, checked against a reference model.
module tb_ext_interrupt_controller;
  localparam int N = 8;
  localparam int IW = 3;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [N-1:0] intSrc = '0;
  logic cfgWen = 1'b0;
  logic cfgSel = 1'b0;
  logic [N-1:0] cfgWData = '0;
  logic [1:0] ackV = '0;
  logic [1:0][N-1:0] maskO;
  logic [1:0][N-1:0] modeO;
  logic [1:0][N-1:0] pendO;
  logic [1:0] reqO;
  logic [1:0][IW-1:0] idO;
  int nTests = 0;
  int nFail = 0;
  bit autoAck = 1'b0;

  logic [N-1:0] hist[$];
  logic [N-1:0] mMask[2];
  logic [N-1:0] mMode[2];
  logic [N-1:0] mPend[2];
  bit mReq[2];
  int mId[2];
  int mPhase[2];
  int mRr[2];

  always #5 clk = ~clk;

  ext_interrupt_controller_if #(.ID_W(IW)) eic0 ();
  ext_interrupt_controller_if #(.ID_W(IW)) eic1 ();

  assign eic0.EIC_IntAck = ackV[0];
  assign eic1.EIC_IntAck = ackV[1];
  assign reqO = {eic1.EIC_IntReq, eic0.EIC_IntReq};
  assign idO = {eic1.EIC_IntId, eic0.EIC_IntId};

  ext_interrupt_controller #(
    .NUM_SRC(N), .ID_W(IW), .SYNC_STAGES(SS), .ARB_RR(0)
  ) dutFp (
    .Sys_Clock(clk), .Sys_Reset(rstN), .Int_Src(intSrc),
    .Cfg_Wen(cfgWen), .Cfg_Sel(cfgSel), .Cfg_WData(cfgWData),
    .Int_Mask(maskO[0]), .Int_Mode(modeO[0]),
    .Int_Pending(pendO[0]), .eic(eic0.master)
  );

  ext_interrupt_controller #(
    .NUM_SRC(N), .ID_W(IW), .SYNC_STAGES(SS), .ARB_RR(1)
  ) dutRr (
    .Sys_Clock(clk), .Sys_Reset(rstN), .Int_Src(intSrc),
    .Cfg_Wen(cfgWen), .Cfg_Sel(cfgSel), .Cfg_WData(cfgWData),
    .Int_Mask(maskO[1]), .Int_Mode(modeO[1]),
    .Int_Pending(pendO[1]), .eic(eic1.master)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] e, int base);
    for (int k = 0; k < N; k++)
      if (e[(base + k) % N]) return (base + k) % N;
    return 0;
  endfunction

  task automatic modelReset();
    hist = {};
    repeat (SS + 1) hist.push_back('0);
    for (int m = 0; m < 2; m++) begin
      mMask[m] = '1;
      mMode[m] = '1;
      mPend[m] = '0;
      mReq[m] = 1'b0;
      mId[m] = 0;
      mPhase[m] = 0;
      mRr[m] = 0;
    end
  endtask

  // hist[j] holds Int_Src as sampled j+1 edges ago.
  task automatic modelEdge();
    logic [N-1:0] s, p, e, np;
    s = hist[SS-1];
    p = hist[SS];
    for (int m = 0; m < 2; m++) begin
      e = mPend[m] & ~mMask[m];
      for (int i = 0; i < N; i++) begin
        if (!mMode[m][i]) np[i] = s[i];
        else if (s[i] && !p[i]) np[i] = 1'b1;
        else if (mPhase[m] == 1 && ackV[m] && mId[m] == i)
          np[i] = 1'b0;
        else np[i] = mPend[m][i];
      end
      if (cfgWen && cfgSel)
        for (int i = 0; i < N; i++)
          if (cfgWData[i] != mMode[m][i]) np[i] = 1'b0;
      case (mPhase[m])
        0: if (e != 0) begin
          mId[m] = pick(e, (m == 1) ? mRr[m] : 0);
          mReq[m] = 1'b1;
          mPhase[m] = 1;
        end
        1: if (ackV[m]) begin
          mReq[m] = 1'b0;
          mPhase[m] = 2;
          if (m == 1) mRr[m] = (mId[m] + 1) % N;
        end
        default: mPhase[m] = 0;
      endcase
      mPend[m] = np;
      if (cfgWen) begin
        if (cfgSel) mMode[m] = cfgWData;
        else mMask[m] = cfgWData;
      end
    end
    hist.push_front(intSrc);
    void'(hist.pop_back());
  endtask

  task automatic compareAll();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("req%0d", m), 32'(reqO[m]), 32'(mReq[m]));
      check($sformatf("id%0d", m), 32'(idO[m]), 32'(mId[m]));
      check($sformatf("pend%0d", m), 32'(pendO[m]), 32'(mPend[m]));
      check($sformatf("mask%0d", m), 32'(maskO[m]), 32'(mMask[m]));
      check($sformatf("mode%0d", m), 32'(modeO[m]), 32'(mMode[m]));
    end
  endtask

  task automatic cycle();
    if (autoAck) ackV = {mReq[1], mReq[0]};
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
    if (autoAck) ackV = '0;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    intSrc = '0;
    cfgWen = 1'b0;
    ackV = '0;
    #1;
    modelReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    compareAll();
  endtask

  task automatic writeCfg(logic sel, logic [N-1:0] d);
    cfgWen = 1'b1;
    cfgSel = sel;
    cfgWData = d;
    cycle();
    cfgWen = 1'b0;
  endtask

  task automatic waitReq(int m, int lim, output int n);
    n = 0;
    while (!reqO[m] && n < lim) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ids[$];
    int expFp[3] = '{2, 4, 6};
    int expRr[4] = '{0, 1, 0, 1};

    modelReset();
    doReset();
    check("rstMask", 32'(maskO[0]), 32'hFF);
    check("rstMode", 32'(modeO[0]), 32'hFF);

    // single edge source, latency and ack
    writeCfg(1'b0, 8'h00);
    intSrc = 8'h20;
    cycle();
    intSrc = '0;
    waitReq(0, 10, n);
    check("lat5", n, 3);
    check("id5", 32'(idO[0]), 5);
    autoAck = 1'b1;
    cycle();
    check("ackPend5", 32'(pendO[0][5]), 0);
    check("ackReq5", 32'(reqO[0]), 0);
    repeat (4) cycle();
    check("idle5", 32'(reqO[0]), 0);

    // fixed priority order
    intSrc = 8'h54;
    cycle();
    intSrc = '0;
    ids = {};
    for (int t = 0; t < 40 && ids.size() < 3; t++) begin
      cycle();
      if (reqO[0]) ids.push_back(int'(idO[0]));
    end
    check("fpCount", ids.size(), 3);
    for (int j = 0; j < ids.size() && j < 3; j++)
      check("fpOrder", ids[j], expFp[j]);
    repeat (4) cycle();
    check("fpEmpty", 32'(pendO[0]), 0);
    autoAck = 1'b0;

    // masked source latches but does not request
    writeCfg(1'b0, 8'h08);
    intSrc = 8'h08;
    cycle();
    intSrc = '0;
    repeat (5) cycle();
    check("mskReq", 32'(reqO[0]), 0);
    check("mskPend", 32'(pendO[0]), 8'h08);
    writeCfg(1'b0, 8'h00);
    waitReq(0, 2, n);
    check("mskGrant", 32'(reqO[0]), 1);
    check("mskId", 32'(idO[0]), 3);
    autoAck = 1'b1;
    repeat (4) cycle();
    autoAck = 1'b0;

    // new edge landing on the ack edge
    intSrc = 8'h02;
    cycle();
    intSrc = '0;
    waitReq(0, 10, n);
    check("eaReq", 32'(reqO[0]), 1);
    intSrc = 8'h02;
    cycle();
    intSrc = '0;
    cycle();
    ackV = {mReq[1], mReq[0]};
    cycle();
    ackV = '0;
    check("eaPend", 32'(pendO[0][1]), 1);
    waitReq(0, 6, n);
    check("eaReReq", 32'(reqO[0]), 1);
    check("eaId", 32'(idO[0]), 1);
    autoAck = 1'b1;
    repeat (4) cycle();
    autoAck = 1'b0;

    // round-robin with two level sources
    doReset();
    writeCfg(1'b0, 8'h00);
    writeCfg(1'b1, 8'h00);
    intSrc = 8'h03;
    autoAck = 1'b1;
    ids = {};
    for (int t = 0; t < 60 && ids.size() < 4; t++) begin
      cycle();
      if (reqO[1]) ids.push_back(int'(idO[1]));
    end
    check("rrCount", ids.size(), 4);
    for (int j = 0; j < ids.size() && j < 4; j++)
      check("rrOrder", ids[j], expRr[j]);
    intSrc = '0;
    repeat (6) cycle();
    autoAck = 1'b0;

    // reset while a request is outstanding
    doReset();
    writeCfg(1'b0, 8'h00);
    intSrc = 8'h10;
    cycle();
    intSrc = '0;
    waitReq(0, 10, n);
    check("preRstReq", 32'(reqO[0]), 1);
    rstN = 1'b0;
    #1;
    check("rstReq", 32'(reqO), 0);
    check("rstId", 32'(idO[0]), 0);
    check("rstPend", 32'(pendO[0]), 0);
    check("rstMask2", 32'(maskO[0]), 32'hFF);
    modelReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    ackV = 2'b11;
    cycle();
    ackV = '0;
    repeat (5) cycle();
    check("strayAck", 32'(reqO), 0);

    // randomized traffic
    doReset();
    writeCfg(1'b0, 8'h00);
    repeat (3000) begin
      intSrc = intSrc ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(29) == 0) begin
        cfgWen = 1'b1;
        cfgSel = 1'($urandom_range(1));
        cfgWData = cfgSel ? N'($urandom)
                          : N'($urandom) & N'($urandom);
      end else begin
        cfgWen = 1'b0;
      end
      for (int m = 0; m < 2; m++)
        ackV[m] = mReq[m] ? ($urandom_range(2) == 0)
                          : ($urandom_range(15) == 0);
      cycle();
    end
    cfgWen = 1'b0;
    ackV = '0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/ext_interrupt_controller.md
Name: ext_interrupt_controller

Overview:
- Parametrised external interrupt controller driving the core's EIC_IntReq/EIC_IntId/EIC_IntAck handshake.
- Generalises the single-ID interrupt path to NUM_SRC sources with:
  - per-source masking;
  - per-source edge or level trigger mode;
  - fixed-priority or round-robin arbitration.
- Sits outside the Kabeta core; its outputs connect directly to the core's EIC ports.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..32).
- ID_W, 3, width of EIC_IntId; must equal clog2(NUM_SRC).
- SYNC_STAGES, 2, synchroniser flops per source (>=2).
- ARB_RR, 0, arbitration: 0 = fixed priority, lowest index wins; 1 = round-robin.
- EDGE_RST, all ones, reset value of the trigger-mode register (1 = edge, 0 = level).

Ports:
- Sys_Clock  in  1  system clock, rising edge.
- Sys_Reset  in  1  asynchronous, active-low reset.
- Int_Src  in  NUM_SRC  raw interrupt lines, asynchronous to Sys_Clock, active high.
- Cfg_Wen  in  1  configuration write strobe.
- Cfg_Sel  in  1  0 = mask register, 1 = trigger-mode register.
- Cfg_WData  in  NUM_SRC  configuration write data.
- Int_Mask  out  NUM_SRC  mask register (1 = masked).
- Int_Mode  out  NUM_SRC  trigger-mode register.
- Int_Pending  out  NUM_SRC  pending bits.
- EIC_IntReq  out  1  interrupt request to core.
- EIC_IntId  out  ID_W  ID of the requested source.
- EIC_IntAck  in  1  acknowledge from core, one-cycle pulse.

Behaviour:
- Reset (Sys_Reset low, asynchronous): clear all state.
  - Sync chains, pending bits, edge-history flops: 0.
  - Int_Mask: all ones (all masked). Int_Mode: EDGE_RST.
  - EIC_IntReq 0, EIC_IntId 0, RR pointer 0, FSM in IDLE.
  - Reset mid-handshake drops the request immediately; no ack is expected afterwards.
- Synchronisation: each Int_Src bit passes through SYNC_STAGES flops to give s[i]. An edge-history flop holds the previous s[i].
- Pending update, registered:
  - Edge mode: set on s[i] & ~prev[i]; cleared when the granted source is acked. Set wins over clear in the same cycle.
  - Level mode: pending[i] = s[i] every cycle; ack has no effect.
  - Masked sources still latch pending but are not eligible for arbitration.
- Mode change: writing mode for source i clears pending[i] in that cycle.
- Configuration write: takes effect on the next edge and is visible on Int_Mask/Int_Mode the following cycle. It does not affect a request already in progress.
- Eligible set: pending & ~Int_Mask.
- FSM, three states:
  - IDLE: if the eligible set is non-zero, select winner w, register EIC_IntId = w, set EIC_IntReq = 1, go to REQ.
  - REQ: hold EIC_IntReq and EIC_IntId stable regardless of mask, mode or pending changes. No withdrawal.
    - On EIC_IntAck: clear pending[w] if w is edge mode; if ARB_RR, set RR pointer = (w+1) mod NUM_SRC; deassert EIC_IntReq; go to GAP.
  - GAP: one cycle with EIC_IntReq = 0, then go to IDLE. Guarantees a low cycle between back-to-back requests.
- EIC_IntAck outside REQ is ignored.
- Arbitration:
  - Fixed priority: the lowest eligible index wins.
  - Round-robin: the first eligible index at or after the RR pointer wins, wrapping modulo NUM_SRC.
- Latency: a source sampled high at edge k raises pending at edge k+SYNC_STAGES and EIC_IntReq at edge k+SYNC_STAGES+1, provided the FSM is in IDLE and the source is unmasked. That is 3 edges for SYNC_STAGES = 2.
- Level source still asserted after ack: re-requested on the first IDLE cycle after GAP.
- EIC_IntId is held at its last value while EIC_IntReq is 0.

Test Plan:
- Reset, then unmask all (Cfg_Sel=0, data 0x00); pulse Int_Src[5] high for 1 cycle -> EIC_IntReq rises 3 edges after sampling with EIC_IntId=5; ack -> Int_Pending[5]=0, EIC_IntReq low for exactly 1 cycle, stays idle.
- Fixed priority: assert edges on sources 6, 2, 4 simultaneously -> grants in order 2, 4, 6, each separated by a 1-cycle GAP; Int_Pending empties to 0x00.
- ARB_RR=1: sources 0 and 1 held high in level mode (mode=0x00) -> grants alternate 0, 1, 0, 1 across four acks.
- Masking: mask=0x08 and edge on source 3 -> no request and Int_Pending=0x08; write mask=0x00 -> request with EIC_IntId=3 within 2 cycles.
- Edge on source 1 in the same cycle as the ack of source 1 -> pending[1] stays 1; a new request with EIC_IntId=1 follows the GAP.
- Assert Sys_Reset low while in REQ -> EIC_IntReq=0, EIC_IntId=0, Int_Pending=0 and Int_Mask=0xFF immediately (asynchronously); a stray ack after release causes no request.
